microsequencer_param: RTL and testbench

Parametrised microprogrammed sequencer, successor to the fixed 5-bit control unit of the SPARC datapath. It holds a writable microstore and a registered control word, and selects the next micro-address from eight sequencing ops. Those ops are continue, jump, dispatch, conditional jump, wait-on-condition, call, return and restart. A micro-subroutine stack and an N-way condition select are new. The block drives all datapath control lines; instruction decode supplies the dispatch address.

---
 rtl/microsequencer_param.sv | 160 ++++++++++++++++
 tb/tb_microsequencer_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer_param.sv
// Parametrised microprogrammed sequencer with a writable microstore,
// a registered control word, a micro-call stack and N-way condition select.
// Every micro-step registers the next micro-address together with the
// microword stored there, so ctrl is valid in the same cycle a state is entered.
module microsequencer_param #(
    parameter int STATE_W     = 5,
    parameter int CTRL_W      = 28,
    parameter int NCOND       = 4,
    parameter int STACK_DEPTH = 2,
    parameter int RESET_STATE = 0,
    localparam int CSW = ($clog2(NCOND) > 1) ? $clog2(NCOND) : 1,
    localparam int UW  = CTRL_W + 3 + 1 + CSW + STATE_W,
    localparam int LW  = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
    input  logic [NCOND-1:0]   cond_in,
    input  logic [STATE_W-1:0] dispatch_addr,
    input  logic               uc_we,
    input  logic [STATE_W-1:0] uc_addr,
    input  logic [UW-1:0]      uc_data,
    output logic [STATE_W-1:0] present_state,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               err,
    output logic [LW-1:0]      stack_level
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [STATE_W-1:0] RESET_ADDR = STATE_W'(RESET_STATE);

    localparam logic [2:0] OP_CONT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_DISPATCH = 3'd2;
    localparam logic [2:0] OP_CJUMP    = 3'd3;
    localparam logic [2:0] OP_CWAIT    = 3'd4;
    localparam logic [2:0] OP_CALL     = 3'd5;
    localparam logic [2:0] OP_RET      = 3'd6;
    localparam logic [2:0] OP_RESTART  = 3'd7;

    // Selected condition input (out-of-range selects read as 0), then optional inversion.
    function automatic logic cond_eval(input logic [NCOND-1:0] cin,
                                       input logic [CSW-1:0]   sel,
                                       input logic             inv_b);
        logic raw;
        raw = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            raw = raw | (cin[i] & (sel == CSW'(i)));
        end
        return raw ^ inv_b;
    endfunction

    logic [UW-1:0]      ustore_r [2**STATE_W];
    logic [STATE_W-1:0] stack_r  [STACK_DEPTH];
    logic [STATE_W-1:0] state_r;
    logic [UW-1:0]      word_r;
    logic               err_r;
    logic [LW-1:0]      level_r;

    logic [2:0]         op_s;
    logic               inv_s;
    logic [CSW-1:0]     csel_s;
    logic [STATE_W-1:0] cr_s;
    logic               c_s;
    logic [STATE_W-1:0] inc_s;
    logic [STATE_W-1:0] nxt_s;
    logic               push_s;
    logic               pop_s;
    logic               clear_s;
    logic               fault_s;
    logic [IW-1:0]      push_idx_s;
    logic [IW-1:0]      top_idx_s;

    assign cr_s       = word_r[STATE_W-1:0];
    assign csel_s     = word_r[STATE_W +: CSW];
    assign inv_s      = word_r[STATE_W + CSW];
    assign op_s       = word_r[STATE_W + CSW + 1 +: 3];
    assign c_s        = cond_eval(cond_in, csel_s, inv_s);
    assign inc_s      = state_r + STATE_W'(1);
    assign push_idx_s = IW'(level_r);
    assign top_idx_s  = IW'(level_r - LW'(1));

    // Next micro-address and stack action selected by the current op.
    always_comb begin
        nxt_s   = inc_s;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        clear_s = 1'b0;
        fault_s = 1'b0;
        case (op_s)
            OP_CONT:     nxt_s = inc_s;
            OP_JUMP:     nxt_s = cr_s;
            OP_DISPATCH: nxt_s = dispatch_addr;
            OP_CJUMP:    nxt_s = c_s ? cr_s : inc_s;
            OP_CWAIT:    nxt_s = c_s ? inc_s : state_r;
            OP_CALL: begin
                if (level_r == LW'(STACK_DEPTH)) begin
                    fault_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                    nxt_s  = cr_s;
                end
            end
            OP_RET: begin
                if (level_r == {LW{1'b0}}) begin
                    fault_s = 1'b1;
                end else begin
                    pop_s = 1'b1;
                    nxt_s = stack_r[top_idx_s];
                end
            end
            OP_RESTART: begin
                nxt_s   = RESET_ADDR;
                clear_s = 1'b1;
            end
            default:     nxt_s = inc_s;
        endcase
    end

    // Microstore write port; only usable while the sequencer is stopped, never reset.
    always_ff @(posedge clk) begin
        if (!run && uc_we) begin
            ustore_r[uc_addr] <= uc_data;
        end
    end

    // Sequencer state, control word, stack and sticky fault; a fault freezes everything.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= RESET_ADDR;
            word_r  <= {UW{1'b0}};
            err_r   <= 1'b0;
            level_r <= {LW{1'b0}};
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {STATE_W{1'b0}};
            end
        end else if (run && !err_r) begin
            if (fault_s) begin
                err_r <= 1'b1;
            end else begin
                state_r <= nxt_s;
                word_r  <= ustore_r[nxt_s];
                if (push_s) begin
                    stack_r[push_idx_s] <= inc_s;
                    level_r             <= level_r + LW'(1);
                end else if (pop_s) begin
                    level_r <= level_r - LW'(1);
                end else if (clear_s) begin
                    level_r <= {LW{1'b0}};
                end
            end
        end
    end

    assign present_state = state_r;
    assign ctrl          = word_r[UW-1 -: CTRL_W];
    assign err           = err_r;
    assign stack_level   = level_r;

endmodule

// File: tb/tb_microsequencer_param.sv
// Self-checking bench for microsequencer_param: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_microsequencer_param;

    localparam int SW = 5;
    localparam int CW = 28;
    localparam int UW = 39;

    logic          clk = 1'b0;
    logic          clr;
    logic          run;
    logic [3:0]    cond_in;
    logic [SW-1:0] dispatch_addr;
    logic          uc_we;
    logic [SW-1:0] uc_addr;
    logic [UW-1:0] uc_data;
    logic [SW-1:0] present_state;
    logic [CW-1:0] ctrl;
    logic          err;
    logic [1:0]    stack_level;

    microsequencer_param dut (
        .clk(clk), .clr(clr), .run(run), .cond_in(cond_in),
        .dispatch_addr(dispatch_addr), .uc_we(uc_we), .uc_addr(uc_addr),
        .uc_data(uc_data), .present_state(present_state), .ctrl(ctrl),
        .err(err), .stack_level(stack_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // behavioural model
    logic [UW-1:0] ms [32];
    int            m_state;
    logic [UW-1:0] m_word;
    logic          m_err;
    int            stk [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [UW-1:0] mk(input logic [CW-1:0] c, input logic [2:0] op,
                                         input logic inv, input logic [1:0] cs,
                                         input logic [SW-1:0] cr);
        return {c, op, inv, cs, cr};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_word  = '0;
        m_err   = 1'b0;
        stk.delete();
    endtask

    task automatic model_step();
        int op, cr, nx, inc;
        bit c;
        if (!run && uc_we) ms[uc_addr] = uc_data;
        if (!clr || !run || m_err) return;
        op  = int'(m_word[10:8]);
        cr  = int'(m_word[4:0]);
        c   = cond_in[m_word[6:5]] ^ m_word[7];
        inc = (m_state + 1) % 32;
        nx  = inc;
        if (op == 1) nx = cr;
        else if (op == 2) nx = int'(dispatch_addr);
        else if (op == 3) nx = c ? cr : inc;
        else if (op == 4) nx = c ? inc : m_state;
        else if (op == 5) begin
            if (stk.size() == 2) begin m_err = 1'b1; return; end
            stk.push_back(inc);
            nx = cr;
        end else if (op == 6) begin
            if (stk.size() == 0) begin m_err = 1'b1; return; end
            nx = stk.pop_back();
        end else if (op == 7) begin
            nx = 0;
            stk.delete();
        end
        m_state = nx;
        m_word  = ms[nx];
    endtask

    // one clock: model advances at the edge, outputs compared at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [SW-1:0] a, input logic [UW-1:0] d);
        run = 1'b0; uc_we = 1'b1; uc_addr = a; uc_data = d;
        tick();
        uc_we = 1'b0;
    endtask

    // reset, then reach address a through the DISPATCH word held at address 1
    task automatic enter(input logic [SW-1:0] a);
        run = 1'b0; clr = 1'b0;
        #1;
        model_reset();
        clr = 1'b1; run = 1'b1; dispatch_addr = a;
        tick();
        tick();
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 64'(present_state), 64'(m_state));
            check("ctrl",  64'(ctrl),          64'(m_word[38:11]));
            check("err",   64'(err),           64'(m_err));
            check("level", 64'(stack_level),   64'(stk.size()));
        end
    end

    logic [CW-1:0] c0, c1, c17;

    initial begin
        clr = 1'b0; run = 1'b0; cond_in = '0; dispatch_addr = '0;
        uc_we = 1'b0; uc_addr = '0; uc_data = '0;
        model_reset();
        for (int i = 0; i < 32; i++) ms[i] = '0;
        @(negedge clk); #1;

        // 1. reset and start
        for (int i = 0; i < 32; i++) wr(5'(i), mk(CW'($urandom()), 3'd0, 1'b0, 2'd0, 5'd0));
        c0 = CW'($urandom()); c1 = CW'($urandom());
        wr(5'd0, mk(c0, 3'd0, 1'b0, 2'd0, 5'd0));
        wr(5'd1, mk(c1, 3'd1, 1'b0, 2'd0, 5'd5));
        clr = 1'b1; chk_en = 1'b1;
        check("rst_state", 64'(present_state), 64'd0);
        check("rst_ctrl",  64'(ctrl), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_level", 64'(stack_level), 64'd0);
        run = 1'b1;
        tick(); check("t1_s1", 64'(present_state), 64'd1); check("t1_c1", 64'(ctrl), 64'(c1));
        tick(); check("t1_s5", 64'(present_state), 64'd5);
        wr(5'd1, mk(c1, 3'd2, 1'b0, 2'd0, 5'd0));

        // 2. conditional jump
        wr(5'd2, mk(CW'($urandom()), 3'd3, 1'b0, 2'd2, 5'd9));
        enter(5'd2); cond_in = 4'b0100; tick(); check("cj_taken", 64'(present_state), 64'd9);
        enter(5'd2); cond_in = 4'b0000; tick(); check("cj_fall", 64'(present_state), 64'd3);
        wr(5'd2, mk(CW'($urandom()), 3'd3, 1'b1, 2'd2, 5'd9));
        enter(5'd2); cond_in = 4'b0000; tick(); check("cj_inv", 64'(present_state), 64'd9);

        // 3. MOC wait
        wr(5'd4, mk(CW'($urandom()), 3'd4, 1'b0, 2'd0, 5'd0));
        cond_in = 4'b0000;
        enter(5'd4);
        check("wait0", 64'(present_state), 64'd4);
        for (int i = 0; i < 3; i++) begin
            tick(); check("wait_hold", 64'(present_state), 64'd4);
        end
        cond_in = 4'b0001;
        tick(); check("wait_go", 64'(present_state), 64'd5);

        // 4. call / return
        wr(5'd6,  mk(CW'($urandom()), 3'd5, 1'b0, 2'd0, 5'd20));
        wr(5'd20, mk(CW'($urandom()), 3'd5, 1'b0, 2'd0, 5'd25));
        wr(5'd25, mk(CW'($urandom()), 3'd6, 1'b0, 2'd0, 5'd0));
        wr(5'd21, mk(CW'($urandom()), 3'd6, 1'b0, 2'd0, 5'd0));
        enter(5'd6);
        check("call_s6", 64'(present_state), 64'd6);  check("call_l0", 64'(stack_level), 64'd0);
        tick(); check("call_s20", 64'(present_state), 64'd20); check("call_l1", 64'(stack_level), 64'd1);
        tick(); check("call_s25", 64'(present_state), 64'd25); check("call_l2", 64'(stack_level), 64'd2);
        tick(); check("ret_s21", 64'(present_state), 64'd21);  check("ret_l1", 64'(stack_level), 64'd1);
        tick(); check("ret_s7", 64'(present_state), 64'd7);    check("ret_l0", 64'(stack_level), 64'd0);
        wr(5'd25, mk(CW'($urandom()), 3'd5, 1'b0, 2'd0, 5'd10));
        enter(5'd6); tick(); tick(); tick();
        check("ovf_err", 64'(err), 64'd1); check("ovf_state", 64'(present_state), 64'd25);
        tick(); tick();
        check("ovf_frozen", 64'(present_state), 64'd25); check("ovf_lvl", 64'(stack_level), 64'd2);

        // 5. dispatch and return underflow
        c17 = CW'($urandom());
        wr(5'd17, mk(c17, 3'd0, 1'b0, 2'd0, 5'd0));
        wr(5'd18, mk(CW'($urandom()), 3'd6, 1'b0, 2'd0, 5'd0));
        enter(5'd17);
        check("disp_state", 64'(present_state), 64'd17); check("disp_ctrl", 64'(ctrl), 64'(c17));
        check("disp_err0", 64'(err), 64'd0);
        tick(); tick();
        check("unf_err", 64'(err), 64'd1); check("unf_state", 64'(present_state), 64'd18);

        // 6. wrap and write lockout
        wr(5'd31, mk(CW'($urandom()), 3'd0, 1'b0, 2'd0, 5'd0));
        enter(5'd31); tick();
        check("wrap_state", 64'(present_state), 64'd0); check("wrap_ctrl", 64'(ctrl), 64'(c0));
        run = 1'b1; uc_we = 1'b1; uc_addr = 5'd0; uc_data = mk(~c0, 3'd1, 1'b0, 2'd0, 5'd3);
        tick(); tick();
        uc_we = 1'b0;
        enter(5'd31); tick();
        check("lock_ctrl", 64'(ctrl), 64'(c0));

        // randomized run
        for (int i = 0; i < 32; i++) wr(5'(i), UW'({$urandom(), $urandom()}));
        wr(5'd1, mk(CW'($urandom()), 3'd2, 1'b0, 2'd0, 5'd0));
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                clr = 1'b0;
                #1;
                model_reset();
            end else begin
                clr = 1'b1;
            end
            run           = ($urandom_range(0, 7) != 0);
            cond_in       = 4'($urandom());
            dispatch_addr = 5'($urandom());
            uc_we         = ($urandom_range(0, 3) == 0);
            uc_addr       = 5'($urandom());
            uc_data       = UW'({$urandom(), $urandom()});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
